// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for the shared memory port: fetch requester, load/store requester and memory side.
// The master modport is the arbiter's view; slave is the view of the stages and memory around it.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;

    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_mask;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_valid;

    logic        mem_request;
    logic        mem_we_re;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    logic        bus_err;

    modport master (
        input  if_req, if_addr, ls_req, ls_we, ls_mask, ls_addr, ls_wdata, mem_rdata, mem_valid,
        output if_rdata, if_valid, ls_rdata, ls_valid,
               mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata, bus_err
    );

    modport slave (
        output if_req, if_addr, ls_req, ls_we, ls_mask, ls_addr, ls_wdata, mem_rdata, mem_valid,
        input  if_rdata, if_valid, ls_rdata, ls_valid,
               mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and the LSU, holding each grant
// until the memory responds or a busy-cycle timeout aborts it with bus_err.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY, RESP} state_e;
    typedef enum logic {OWNER_IF, OWNER_LS} owner_e;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    owner_e      last_grant_q, last_grant_d;
    logic [15:0] count_q, count_d;

    logic        mem_request_q, mem_request_d;
    logic        mem_we_re_q, mem_we_re_d;
    logic [3:0]  mem_mask_q, mem_mask_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        ls_valid_q, ls_valid_d;
    logic        bus_err_q, bus_err_d;

    logic        busy;
    logic        timeout_hit;
    logic        grant_if;
    logic [31:0] resp_data;

    assign busy        = (state_q == IF_BUSY) || (state_q == LS_BUSY);
    // A response in the last allowed cycle still wins over the timeout.
    assign timeout_hit = busy && !bus.mem_valid && (count_q == TIMEOUT_LAST);
    assign grant_if    = bus.if_req && (!bus.ls_req || (last_grant_q == OWNER_LS));
    assign resp_data   = bus.mem_valid ? bus.mem_rdata : 32'h0;

    always_comb begin
        // NOTE: every _d starts from its _q (pulses from 0) so no path through the case infers a latch.
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        count_d       = count_q;
        mem_request_d = mem_request_q;
        mem_we_re_d   = mem_we_re_q;
        mem_mask_d    = mem_mask_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_rdata_d    = if_rdata_q;
        ls_rdata_d    = ls_rdata_q;
        if_valid_d    = 1'b0;
        ls_valid_d    = 1'b0;
        bus_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.ls_req) begin
                    mem_request_d = 1'b1;
                    count_d       = 16'h0;
                    if (grant_if) begin
                        state_d      = IF_BUSY;
                        last_grant_d = OWNER_IF;
                        mem_we_re_d  = 1'b0;
                        mem_mask_d   = 4'hF;
                        mem_addr_d   = bus.if_addr;
                        mem_wdata_d  = 32'h0;
                    end else begin
                        state_d      = LS_BUSY;
                        last_grant_d = OWNER_LS;
                        mem_we_re_d  = bus.ls_we;
                        mem_mask_d   = bus.ls_mask;
                        mem_addr_d   = bus.ls_addr;
                        mem_wdata_d  = bus.ls_wdata;
                    end
                end
            end
            IF_BUSY, LS_BUSY: begin
                if (bus.mem_valid || timeout_hit) begin
                    state_d       = RESP;
                    mem_request_d = 1'b0;
                    bus_err_d     = !bus.mem_valid;
                    if (state_q == IF_BUSY) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = resp_data;
                    end else begin
                        ls_valid_d = 1'b1;
                        ls_rdata_d = resp_data;
                    end
                end else if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the edge, and <= makes every flop update from pre-edge values.
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= OWNER_LS;
            count_q       <= 16'h0;
            mem_request_q <= 1'b0;
            mem_we_re_q   <= 1'b0;
            mem_mask_q    <= 4'h0;
            mem_addr_q    <= 32'h0;
            mem_wdata_q   <= 32'h0;
            if_rdata_q    <= 32'h0;
            if_valid_q    <= 1'b0;
            ls_rdata_q    <= 32'h0;
            ls_valid_q    <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            count_q       <= count_d;
            mem_request_q <= mem_request_d;
            mem_we_re_q   <= mem_we_re_d;
            mem_mask_q    <= mem_mask_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_rdata_q    <= if_rdata_d;
            if_valid_q    <= if_valid_d;
            ls_rdata_q    <= ls_rdata_d;
            ls_valid_q    <= ls_valid_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign bus.mem_request = mem_request_q;
    assign bus.mem_we_re   = mem_we_re_q;
    assign bus.mem_mask    = mem_mask_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.ls_rdata    = ls_rdata_q;
    assign bus.ls_valid    = ls_valid_q;
    assign bus.bus_err     = bus_err_q;
endmodule
